tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter_pkg.sv | 17 +
 rtl/tx_arb_pick.sv | 36 +++
 rtl/tx_arbiter.sv | 114 +++++++++++
 tb/tb_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package tx_arbiter_pkg;

    localparam int unsigned DATA_W = 8;

    // Requester indices, also the encoding of grant and last-served
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tx_arb_pick.sv
// Combinational winner selection between two requesters.
// TX_ARB_FIXED_PRIORITY_EN: when defined, requester 0 always wins a tie;
// otherwise a tie goes to the requester not served last.
module tx_arb_pick
    import tx_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic winner_c_o
);

`ifdef TX_ARB_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = last_i;

    // Fixed priority: requester 1 only when requester 0 is silent
    always_comb begin
        winner_c_o = REQ0;
        if (!req0_i && req1_i) begin
            winner_c_o = REQ1;
        end
    end
`else
    // Round-robin: tie goes to the requester other than the last one served
    always_comb begin
        winner_c_o = REQ0;
        if (req0_i && req1_i) begin
            winner_c_o = ~last_i;
        end else if (req1_i) begin
            winner_c_o = REQ1;
        end
    end
`endif

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates two byte requesters onto one shared UART transmitter.
// Optional build macro TX_ARB_FIXED_PRIORITY_EN selects fixed priority
// (requester 0 wins ties) instead of the default round-robin.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned BUSY_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic              tx_err,
    output logic              grant
);

    localparam int unsigned CNT_W = $clog2(BUSY_WAIT + 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              last_q;
    logic              grant_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_wr_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              tx_err_q;
    logic              winner_c;
    logic              can_pick_c;

    tx_arb_pick u_pick (
        .req0_i     (req0),
        .req1_i     (req1),
        .last_i     (last_q),
        .winner_c_o (winner_c)
    );

    // Next timeout count; the FSM leaves WAIT_BUSY when it hits BUSY_WAIT, so it never wraps
    assign cnt_d = cnt_q + CNT_W'(1);

    // A requester still sees its own ack this cycle, so skip picking during the ack pulse
    assign can_pick_c = (req0 | req1) & ~tx_busy & ~ack0_q & ~ack1_q;

    // Arbitration FSM with registered strobes, grant and byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= REQ1;
            grant_q   <= REQ0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            tx_wr_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            tx_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (can_pick_c) begin
                        grant_q   <= winner_c;
                        tx_data_q <= (winner_c == REQ1) ? data1 : data0;
                        tx_wr_q   <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_d == CNT_W'(BUSY_WAIT)) begin
                        tx_err_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        ack0_q  <= (grant_q == REQ0);
                        ack1_q  <= (grant_q == REQ1);
                        last_q  <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;
    assign tx_err  = tx_err_q;
    assign grant   = grant_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter.
module tb_tx_arbiter;

    logic       clk;
    logic       reset;
    logic       req0;
    logic [7:0] data0;
    logic       req1;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic       tx_err;
    logic       grant;

    int n_cmp;
    int n_bad;

    // Event counters, sampled at the active edge (pre-update values)
    int wr_cnt;
    int ack0_cnt;
    int ack1_cnt;
    int err_cnt;
    int excl_bad;

    tx_arbiter #(.BUSY_WAIT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .data0   (data0),
        .req1    (req1),
        .data1   (data1),
        .ack0    (ack0),
        .ack1    (ack1),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_busy (tx_busy),
        .tx_err  (tx_err),
        .grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_wr)  wr_cnt   <= wr_cnt + 1;
        if (ack0)   ack0_cnt <= ack0_cnt + 1;
        if (ack1)   ack1_cnt <= ack1_cnt + 1;
        if (tx_err) err_cnt  <= err_cnt + 1;
        if ((ack0 && ack1) || (tx_err && (ack0 || ack1))) excl_bad <= excl_bad + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; tx_busy = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_wr(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (tx_wr) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({tx_wr, ack0, ack1, tx_err, grant} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got wr/a0/a1/err/gnt=%b want 00000", {tx_wr, ack0, ack1, tx_err, grant});
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_tx_data: got %h want 00", tx_data);
        end
    endtask

    task automatic test_single();
        bit seen;
        int wr0, a0;
        do_reset();
        wr0 = wr_cnt; a0 = ack0_cnt;
        req0 = 1'b1; data0 = 8'h4D;
        wait_wr(5, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL single_wr: got no tx_wr want tx_wr within 5 cycles");
        end
        n_cmp++;
        if (tx_data !== 8'h4D || grant !== 1'b0) begin
            n_bad++;
            $display("FAIL single_data: got data=%h grant=%b want 4d/0", tx_data, grant);
        end
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b0 || tx_data !== 8'h4D) begin
            n_bad++;
            $display("FAIL single_hold: got ack0=%b data=%h want 0/4d", ack0, tx_data);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_ack: got ack0=%b ack1=%b want 1/0", ack0, ack1);
        end
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wr_cnt - wr0 != 1 || ack0_cnt - a0 != 1) begin
            n_bad++;
            $display("FAIL single_counts: got wr=%0d ack0=%0d want 1/1", wr_cnt - wr0, ack0_cnt - a0);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [7:0] exp_d [3];
        logic       exp_g [3];
        do_reset();
`ifdef TX_ARB_FIXED_PRIORITY_EN
        exp_d[0] = 8'hE3; exp_d[1] = 8'hE3; exp_d[2] = 8'hE3;
        exp_g[0] = 1'b0;  exp_g[1] = 1'b0;  exp_g[2] = 1'b0;
`else
        exp_d[0] = 8'hE3; exp_d[1] = 8'h55; exp_d[2] = 8'hE3;
        exp_g[0] = 1'b0;  exp_g[1] = 1'b1;  exp_g[2] = 1'b0;
`endif
        req0 = 1'b1; data0 = 8'hE3;
        req1 = 1'b1; data1 = 8'h55;
        for (int i = 0; i < 3; i++) begin
            wait_wr(12, seen);
            n_cmp++;
            if (!seen || tx_data !== exp_d[i] || grant !== exp_g[i]) begin
                n_bad++;
                $display("FAIL b2b_byte%0d: got seen=%b data=%h grant=%b want 1/%h/%b", i, seen, tx_data, grant, exp_d[i], exp_g[i]);
            end
            tx_busy = 1'b1;
            repeat (3) @(negedge clk);
            tx_busy = 1'b0;
            wait_ack(5, seen);
            n_cmp++;
            if (!seen || ack0 !== ~exp_g[i] || ack1 !== exp_g[i]) begin
                n_bad++;
                $display("FAIL b2b_ack%0d: got seen=%b ack0=%b ack1=%b want 1/%b/%b", i, seen, ack0, ack1, ~exp_g[i], exp_g[i]);
            end
            n_cmp++;
            if (tx_wr !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_spacing%0d: got tx_wr=%b in ack cycle want 0", i, tx_wr);
            end
            if (i == 2) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit seen;
        int a1;
        do_reset();
        a1 = ack1_cnt;
        req1 = 1'b1; data1 = 8'hA5;
        wait_wr(5, seen);
        n_cmp++;
        if (!seen || grant !== 1'b1 || tx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL timeout_wr: got seen=%b grant=%b data=%h want 1/1/a5", seen, grant, tx_data);
        end
        repeat (16) @(negedge clk);
        n_cmp++;
        if (tx_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got tx_err=%b one cycle before limit want 0", tx_err);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_err !== 1'b1 || ack1 !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: got tx_err=%b ack1=%b want 1/0", tx_err, ack1);
        end
        req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (tx_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: got tx_err=%b want 0", tx_err);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ack1_cnt != a1 || tx_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_idle: got ack1 delta=%0d tx_wr=%b want 0/0", ack1_cnt - a1, tx_wr);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int a0, a1, e0;
        do_reset();
        a0 = ack0_cnt; a1 = ack1_cnt; e0 = err_cnt;
        req1 = 1'b1; data1 = 8'h3C;
        wait_wr(5, seen);
        tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({tx_wr, ack0, ack1, tx_err, grant} !== 5'b0 || tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid: got wr/a0/a1/err/gnt=%b data=%h want 00000/00", {tx_wr, ack0, ack1, tx_err, grant}, tx_data);
        end
        req1 = 1'b0; tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (ack0_cnt != a0 || ack1_cnt != a1 || err_cnt != e0) begin
            n_bad++;
            $display("FAIL reset_mid_noack: got ack0/ack1/err deltas=%0d/%0d/%0d want 0/0/0", ack0_cnt - a0, ack1_cnt - a1, err_cnt - e0);
        end
    endtask

    task automatic test_busy_block();
        bit seen;
        int wr0;
        do_reset();
        tx_busy = 1'b1;
        @(negedge clk);
        wr0 = wr_cnt;
        req0 = 1'b1; data0 = 8'h96;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (wr_cnt != wr0 || tx_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_block: got wr delta=%0d tx_wr=%b want 0/0", wr_cnt - wr0, tx_wr);
        end
        tx_busy = 1'b0;
        wait_wr(3, seen);
        n_cmp++;
        if (!seen || tx_data !== 8'h96) begin
            n_bad++;
            $display("FAIL busy_release: got seen=%b data=%h want 1/96", seen, tx_data);
        end
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
        wait_ack(4, seen);
        n_cmp++;
        if (!seen || ack0 !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_ack: got seen=%b ack0=%b want 1/1", seen, ack0);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (excl_bad != 0) begin
            n_bad++;
            $display("FAIL exclusive: got %0d overlapping ack/err cycles want 0", excl_bad);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        wr_cnt = 0; ack0_cnt = 0; ack1_cnt = 0; err_cnt = 0; excl_bad = 0;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; tx_busy = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_busy_block();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
